// File: rtl/key_event_queue_if.sv
// Port bundle for key_event_queue: mode/keycode/pop in, FIFO head and status out.
interface key_event_queue_if #(
    parameter int KEY_W = 8,
    parameter int DEPTH = 4
);
    logic                         hold;
    logic [KEY_W-1:0]             keycode;
    logic                         pop;
    logic [KEY_W-1:0]             key;
    logic                         key_valid;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         overflow;

    modport master (output hold, keycode, pop, input key, key_valid, count, overflow);
    modport slave  (input hold, keycode, pop, output key, key_valid, count, overflow);
endinterface

// File: rtl/key_event_queue.sv
// Keycode conditioner: press events into a DEPTH-entry FIFO, or level pass-through on hold.
// Optional auto-repeat FSM is compiled in when KEY_REPEAT_EN is defined.
module key_event_queue #(
    parameter int KEY_W        = 8,
    parameter int DEPTH        = 4,
    parameter int REPEAT_DELAY = 12_500_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic              Clk,
    input  logic              Reset,
    key_event_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REPEAT_DELAY < 2 ||
        REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_params
        $error("key_event_queue: illegal parameter set");
    end

    logic [KEY_W-1:0] kc_q, kc_d;
    logic [KEY_W-1:0] kc_prev_q, kc_prev_d;
    logic             hold_prev_q, hold_prev_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [KEY_W-1:0] mem [DEPTH];

    logic press, flush, push_req, do_push, do_pop, full, rep_push;

    assign press    = (kc_q != '0) && (kc_q != kc_prev_q);
    assign flush    = (bus.hold != hold_prev_q);
    assign full     = (count_q == CW'(DEPTH));
    assign push_req = !bus.hold && (press || rep_push);
    assign do_pop   = !bus.hold && bus.pop && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push  = push_req && (!full || do_pop);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        kc_d        = bus.keycode;
        kc_prev_d   = kc_q;
        hold_prev_d = bus.hold;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
            if (push_req && !do_push) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (Reset) begin
            kc_q        <= '0;
            kc_prev_q   <= '0;
            hold_prev_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            kc_q        <= kc_d;
            kc_prev_q   <= kc_prev_d;
            hold_prev_q <= hold_prev_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // NOTE: storage is not reset; count_q gates every read, so stale entries are never visible.
    always_ff @(posedge Clk) begin
        if (do_push && !flush) mem[wr_ptr_q] <= kc_q;
    end

`ifdef KEY_REPEAT_EN
    localparam int RCW = $clog2(REPEAT_DELAY);

    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_REPEATING} rep_state_t;

    rep_state_t     state_q, state_d;
    logic [RCW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rep_push = 1'b0;
        if (bus.hold || kc_q == '0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (press) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_PRESSED: begin
                    if (cnt_q == RCW'(REPEAT_DELAY - 1)) begin
                        rep_push = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_REPEATING;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_REPEATING: begin
                    if (cnt_q == RCW'(REPEAT_RATE - 1)) begin
                        rep_push = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign rep_push = 1'b0;
`endif

    // Level mode shows the sampled keycode; event mode shows the FIFO head.
    assign bus.key       = bus.hold ? kc_q : ((count_q != '0) ? mem[rd_ptr_q] : '0);
    assign bus.key_valid = bus.hold ? (kc_q != '0) : (count_q != '0);
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue (DEPTH=4, REPEAT_DELAY=10, REPEAT_RATE=4).
// Repeat expectations follow KEY_REPEAT_EN.
module tb_key_event_queue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_event_queue_if #(.KEY_W(8), .DEPTH(4)) kif ();

    key_event_queue #(
        .KEY_W(8), .DEPTH(4), .REPEAT_DELAY(10), .REPEAT_RATE(4)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (kif.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_release(input logic [7:0] v);
        kif.keycode = v;
        tick(1);
        kif.keycode = 8'h00;
        tick(1);
    endtask

    task automatic pop1();
        kif.pop = 1'b1;
        tick(1);
        kif.pop = 1'b0;
    endtask

    task automatic mode_flush();
        kif.hold = 1'b1;
        tick(1);
        kif.hold = 1'b0;
        tick(1);
    endtask

    initial begin
        rst         = 1'b1;
        kif.hold    = 1'b0;
        kif.keycode = 8'h00;
        kif.pop     = 1'b0;
        tick(2);
        check("rst_key",      kif.key,       0);
        check("rst_valid",    kif.key_valid, 0);
        check("rst_count",    kif.count,     0);
        check("rst_overflow", kif.overflow,  0);
        rst = 1'b0;
        tick(1);

        // Single press: two-edge latency, survives release, pop empties.
        kif.keycode = 8'h1A;
        tick(1);
        check("t1_latency_count", kif.count, 0);
        tick(1);
        check("t1_key",   kif.key,       8'h1A);
        check("t1_valid", kif.key_valid, 1);
        check("t1_count", kif.count,     1);
        tick(1);
        kif.keycode = 8'h00;
        tick(3);
        check("t1_rel_key",   kif.key,   8'h1A);
        check("t1_rel_count", kif.count, 1);
        pop1();
        check("t1_pop_count", kif.count,     0);
        check("t1_pop_key",   kif.key,       0);
        check("t1_pop_valid", kif.key_valid, 0);

        // Five presses into four entries: last one dropped, overflow sticky.
        for (int v = 4; v <= 8; v++) press_release(8'(v));
        check("t2_count",    kif.count,    4);
        check("t2_overflow", kif.overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_head%0d", i), kif.key, 32'(4 + i));
            pop1();
        end
        check("t2_empty",       kif.count,    0);
        check("t2_ovf_sticky",  kif.overflow, 1);
        mode_flush();
        check("t2_ovf_cleared", kif.overflow, 0);

        // Push and pop together on a full FIFO.
        for (int v = 8'h11; v <= 8'h14; v++) press_release(8'(v));
        check("t3_full", kif.count, 4);
        kif.keycode = 8'h09;
        tick(1);
        kif.pop = 1'b1;
        tick(1);
        kif.pop = 1'b0;
        kif.keycode = 8'h00;
        check("t3_count",    kif.count,    4);
        check("t3_overflow", kif.overflow, 0);
        check("t3_head",     kif.key,      8'h12);
        pop1();
        pop1();
        pop1();
        check("t3_last", kif.key, 8'h09);
        pop1();
        check("t3_empty", kif.count, 0);

        // Held key: repeat pushes at +10, +14, +18, +22 (dropped).
        kif.keycode = 8'h1A;
        tick(2);
        check("t4_press", kif.count, 1);
        tick(9);
        check("t4_pre_delay", kif.count, 1);
`ifdef KEY_REPEAT_EN
        tick(1);
        check("t4_rep10", kif.count, 2);
        tick(3);
        check("t4_pre_rate", kif.count, 2);
        tick(1);
        check("t4_rep14", kif.count, 3);
        tick(4);
        check("t4_rep18",     kif.count,    4);
        check("t4_ovf18",     kif.overflow, 0);
        tick(4);
        check("t4_ovf22",     kif.overflow, 1);
        tick(4);
        check("t4_rep26",     kif.count,    4);
`else
        tick(17);
        check("t4_single",    kif.count,    1);
        check("t4_no_ovf",    kif.overflow, 0);
`endif
        kif.keycode = 8'h00;
        tick(2);
        mode_flush();
        check("t4_flushed", kif.count, 0);

        // Level mode.
        press_release(8'h21);
        press_release(8'h22);
        check("t5_count2", kif.count, 2);
        kif.hold = 1'b1;
        tick(1);
        check("t5_flush_count", kif.count,    0);
        check("t5_flush_ovf",   kif.overflow, 0);
        kif.keycode = 8'h1A;
        tick(1);
        check("t5_level_key",   kif.key,       8'h1A);
        check("t5_level_valid", kif.key_valid, 1);
        pop1();
        check("t5_pop_key",   kif.key,   8'h1A);
        check("t5_pop_count", kif.count, 0);
        kif.keycode = 8'h00;
        tick(1);
        check("t5_rel_valid", kif.key_valid, 0);
        check("t5_rel_key",   kif.key,       0);
        kif.hold = 1'b0;
        tick(1);
        check("t5_no_push", kif.count, 0);

        // Asynchronous reset mid-repeat.
        kif.keycode = 8'h33;
        tick(2);
        tick(14);
`ifdef KEY_REPEAT_EN
        check("t6_pre_count", kif.count, 3);
`else
        check("t6_pre_count", kif.count, 1);
`endif
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_key",   kif.key,       0);
        check("t6_rst_valid", kif.key_valid, 0);
        check("t6_rst_count", kif.count,     0);
        check("t6_rst_ovf",   kif.overflow,  0);
        kif.keycode = 8'h00;
        tick(2);
        #3;
        rst = 1'b0;
        tick(3);
        check("t6_quiet_count", kif.count,     0);
        check("t6_quiet_valid", kif.key_valid, 0);
        kif.keycode = 8'h44;
        tick(2);
        check("t6_fresh_key",   kif.key,   8'h44);
        check("t6_fresh_count", kif.count, 1);
        kif.keycode = 8'h00;
        tick(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
